usart_receiver: RTL

Receive half of the USART: oversamples the serial input with the 16x receiver clock enable and detects start bits. Assembles 5–9-bit frames LSB first, with optional parity, and loads each completed character into a single-level receive buffer (UDR read side) with RXC, FE, UPE and DOR flags. It sits beside the transmit data path and shares the same baud generator enables and UCSR configuration bits.

---
 rtl/usart_pkg.sv | 35 +++
 rtl/usart_rx_sampler.sv | 73 +++++++
 rtl/usart_receiver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/usart_pkg.sv
// Shared USART definitions: FSM states, UCSZ/UPM encodings and character-size decode.
package usart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } usart_state_e;

  localparam logic [2:0] UcszBits5 = 3'b000;
  localparam logic [2:0] UcszBits6 = 3'b001;
  localparam logic [2:0] UcszBits7 = 3'b010;
  localparam logic [2:0] UcszBits8 = 3'b011;
  localparam logic [2:0] UcszBits9 = 3'b111;

  localparam logic [1:0] UpmEven = 2'b10;
  localparam logic [1:0] UpmOdd  = 2'b11;

  // Reserved UCSZ codes fall back to 8 data bits.
  function automatic logic [3:0] data_bits(input logic [2:0] ucsz);
    logic [3:0] n;
    case (ucsz)
      UcszBits5: n = 4'd5;
      UcszBits6: n = 4'd6;
      UcszBits7: n = 4'd7;
      UcszBits8: n = 4'd8;
      UcszBits9: n = 4'd9;
      default:   n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/usart_rx_sampler.sv
// RxD synchronizer, start-edge detect, 16x tick counter and per-bit decision.
// USART_RX_MAJORITY_EN selects a 2-of-3 vote over ticks 7/8/9 instead of tick 9 alone.
module usart_rx_sampler
  import usart_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic en_i,
  input  logic active_i,
  input  logic clr_i,
  input  logic rxd_i,
  output logic start_o,
  output logic dec_o,
  output logic wrap_o,
  output logic bit_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic [3:0] cnt_q, cnt_d;
  logic       rx_s;

  assign rx_s    = sync_q[1];
  assign start_o = tick_i & en_i & ~active_i & prev_q & ~rx_s;
  assign dec_o   = tick_i & active_i & (cnt_q == 4'd9);
  assign wrap_o  = tick_i & active_i & (cnt_q == 4'd15);

  // The detect tick itself is count 0, so the counter leaves it holding 1.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i) begin
      cnt_d = 4'd0;
    end else if (active_i) begin
      if (tick_i) cnt_d = cnt_q + 4'd1;
    end else if (start_o) begin
      cnt_d = 4'd1;
    end else begin
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      cnt_q  <= 4'd0;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      if (tick_i) prev_q <= rx_s;
      cnt_q  <= cnt_d;
    end
  end

`ifdef USART_RX_MAJORITY_EN
  logic s7_q, s8_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s7_q <= 1'b1;
      s8_q <= 1'b1;
    end else if (tick_i) begin
      if (cnt_q == 4'd7) s7_q <= rx_s;
      if (cnt_q == 4'd8) s8_q <= rx_s;
    end
  end

  assign bit_o = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
`else
  assign bit_o = rx_s;
`endif

endmodule

// File: rtl/usart_receiver.sv
// USART receive path: frame FSM, shift register, parity check and single-level UDR buffer.
// Build option USART_RX_MAJORITY_EN enables majority-vote bit sampling in the sampler.
module usart_receiver
  import usart_pkg::*;
(
  input  logic       i_fosk,
  input  logic       i_rst,
  input  logic       i_rxclk,
  input  logic       i_rxen,
  input  logic       i_RxD,
  input  logic [2:0] i_UCSZ,
  input  logic [1:0] i_UPM,
  input  logic       i_re_udr,
  output logic [7:0] o_rx,
  output logic       o_rx8,
  output logic       o_rxc,
  output logic       o_fe,
  output logic       o_upe,
  output logic       o_dor
);

  usart_state_e state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [8:0]   shift_q, shift_d;
  logic         par_q, par_d;
  logic         perr_q, perr_d;
  logic [7:0]   rx_q, rx_d;
  logic         rx8_q, rx8_d;
  logic         rxc_q, rxc_d;
  logic         fe_q, fe_d;
  logic         upe_q, upe_d;
  logic         dor_q, dor_d;

  logic       start, dec, wrap, bit_val, clr;
  logic [3:0] nbits;

  assign nbits = data_bits(i_UCSZ);

  usart_rx_sampler u_sampler (
    .clk_i    (i_fosk),
    .rst_i    (i_rst),
    .tick_i   (i_rxclk),
    .en_i     (i_rxen),
    .active_i (state_q != StIdle),
    .clr_i    (clr),
    .rxd_i    (i_RxD),
    .start_o  (start),
    .dec_o    (dec),
    .wrap_o   (wrap),
    .bit_o    (bit_val)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    perr_d  = perr_q;
    rx_d    = rx_q;
    rx8_d   = rx8_q;
    rxc_d   = rxc_q;
    fe_d    = fe_q;
    upe_d   = upe_q;
    dor_d   = dor_q;
    clr     = 1'b0;

    // A same-cycle transfer below overrides the read.
    if (i_re_udr) rxc_d = 1'b0;

    if (!i_rxen) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StStart;
            idx_d   = 4'd0;
            shift_d = 9'd0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
          end
        end
        StStart: begin
          if (dec && bit_val) begin
            state_d = StIdle;
            clr     = 1'b1;
          end else if (wrap) begin
            state_d = StData;
            idx_d   = 4'd0;
          end
        end
        StData: begin
          if (dec) begin
            if (idx_q <= 4'd8) shift_d[idx_q] = bit_val;
            par_d = par_q ^ bit_val;
          end
          if (wrap) begin
            if (idx_q == nbits - 4'd1) begin
              state_d = i_UPM[1] ? StParity : StStop;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        StParity: begin
          if (dec) perr_d = par_q ^ bit_val ^ (i_UPM == UpmOdd);
          if (wrap) state_d = StStop;
        end
        StStop: begin
          if (dec) begin
            state_d = StIdle;
            clr     = 1'b1;
            if (!rxc_q) begin
              rx_d  = shift_q[7:0];
              rx8_d = shift_q[8];
              rxc_d = 1'b1;
              fe_d  = ~bit_val;
              upe_d = perr_q;
              dor_d = 1'b0;
            end else begin
              dor_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_fosk) begin
    if (i_rst) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      shift_q <= 9'd0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      rx_q    <= 8'd0;
      rx8_q   <= 1'b0;
      rxc_q   <= 1'b0;
      fe_q    <= 1'b0;
      upe_q   <= 1'b0;
      dor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      rx_q    <= rx_d;
      rx8_q   <= rx8_d;
      rxc_q   <= rxc_d;
      fe_q    <= fe_d;
      upe_q   <= upe_d;
      dor_q   <= dor_d;
    end
  end

  assign o_rx  = rx_q;
  assign o_rx8 = rx8_q;
  assign o_rxc = rxc_q;
  assign o_fe  = fe_q;
  assign o_upe = upe_q;
  assign o_dor = dor_q;

endmodule
